logic_trigger_sequencer: RTL and testbench
==========================================

# logic_trigger_sequencer

Parametrised trigger sequencer for the logic-analyzer capture path, running entirely in the `clk_ram_2x` domain. It generalises the fixed-depth, instant-trigger controller in several ways:
- runtime pre/post-trigger depths;
- a real pattern/edge trigger across `NUM_CHANNELS` sample bits, with an auto-trigger timeout;
- single or repeat acquisition;
- a download handshake and an abort path.

Its `trig_rst`, `capture_en` and `capture_flush` outputs feed the existing per-port synchronizers.

## Interface
Parameters:
- `NUM_CHANNELS`, 16: width of the sample vector evaluated by the trigger.
- `COUNT_WIDTH`, 32: width of the depth, timeout and position counters.
- `RESET_CYCLES`, 32: cycles `trig_rst` is held high.
- `SETTLE_CYCLES`, 32: cycles after `trig_rst` falls before `capture_en` rises.

Ports:
- `clk_ram_2x` in 1: sole clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `arm_req` in 1: level; high requests acquisition, low aborts or releases.
- `repeat_mode` in 1: 0 = single-shot, 1 = re-arm automatically after each download.
- `auto_trig` in 1: 1 = force a trigger after `auto_timeout` cycles in ARMED.
- `force_trig` in 1: single-cycle pulse; triggers immediately when in ARMED.
- `pre_trig_size` in COUNT_WIDTH: PRE_TRIG duration in cycles.
- `post_trig_size` in COUNT_WIDTH: POST_TRIG duration in cycles.
- `auto_timeout` in COUNT_WIDTH: ARMED timeout in cycles.
- `trig_mask` in NUM_CHANNELS: channels compared against `trig_value`.
- `trig_value` in NUM_CHANNELS: required level per masked channel.
- `trig_edge_mask` in NUM_CHANNELS: channels of which at least one must change.
- `sample` in NUM_CHANNELS: live sample vector, one per cycle.
- `download_done` in 1: pulse from the readout engine when the waveform has been consumed.
- `trig_rst` out 1: reset to the capture ports and arbiter.
- `capture_en` out 1: level enabling sample capture.
- `capture_flush` out 1: single-cycle pulse at end of capture.
- `triggered` out 1: single-cycle pulse on the trigger event.
- `trig_was_auto` out 1: latched; 1 if the last trigger came from timeout or `force_trig`.
- `trig_state` out 3: current state encoding.
- `acq_count` out 16: completed acquisitions, wraps at 2^16.

## Operation
- **Configuration latch.** All `*_size`, `auto_timeout`, `trig_*` and mode inputs are latched on the IDLE→RESET transition. Changes after that take effect only at the next arm or re-arm.
- **IDLE (0).** When `arm_req`=1: set `trig_rst`=1, clear the counter, go to RESET.
- **RESET (1).**
  - `trig_rst` is high for exactly RESET_CYCLES cycles.
  - After that, wait SETTLE_CYCLES cycles, then set `capture_en`=1 and go to PRE_TRIG.
- **PRE_TRIG (2).** Lasts exactly `pre_trig_size` cycles, then goes to ARMED. A size of 0 skips PRE_TRIG: RESET goes directly to ARMED.
- **ARMED (3).** Leaves on the first of the following:
  - match;
  - `force_trig`;
  - `auto_trig`=1 with the timeout counter equal to `auto_timeout`-1.

  On exit: pulse `triggered`, load `trig_was_auto`, clear the counter, go to POST_TRIG. With `auto_timeout`=0 and `auto_trig`=1, the trigger fires on the first ARMED cycle.
- **POST_TRIG (4).**
  - Lasts exactly `post_trig_size` cycles. On the final cycle: `capture_en`←0, `capture_flush` pulses 1 cycle, go to DONE.
  - `post_trig_size`=0 means flush on the first POST_TRIG cycle.
- **DONE (5).** On `download_done`: increment `acq_count`.
  - If `repeat_mode` and `arm_req`: go to RESET with `trig_rst`=1 (config relatched).
  - Otherwise: go to CLEAR.
- **CLEAR (6).** Wait for `arm_req`=0, then go to IDLE.
- **Match.**
  - `sample` is registered (`s_q`); the previous registered sample is also held (`s_qq`).
  - Match = (((`s_q` ^ value) & mask) == 0) AND (edge_mask == 0 OR ((`s_q` ^ `s_qq`) & edge_mask) != 0).
  - With mask=0 and edge_mask=0, the trigger fires on the first ARMED cycle.
- **Abort.** `arm_req`=0 in RESET, PRE_TRIG, ARMED or POST_TRIG:
  - next cycle: `trig_rst`=0, `capture_en`=0, go to IDLE;
  - no flush, no `triggered` pulse, `acq_count` unchanged.
- **Simultaneous events.**
  - Abort has priority over trigger and flush.
  - `force_trig` and match together give one `triggered` pulse with `trig_was_auto`=0.
  - Timeout and match together: `trig_was_auto`=0.
- **Widths.** Counters compare with equality at COUNT_WIDTH and never overflow within a state. `acq_count` wraps modulo 2^16.

## Timing
- **Reset values.**
  - State = IDLE.
  - `trig_rst`, `capture_en`, `capture_flush`, `triggered`, `trig_was_auto` = 0.
  - `acq_count`, `s_q`, `s_qq` = 0.
- **All outputs are registered.**
- **Trigger latency.** `sample` at cycle t → `s_q` at t+1 → `triggered` high and state=POST_TRIG at t+2.
- **Force latency.** `force_trig` at cycle t → `triggered` at t+1.
- **Arm to capture.** `arm_req` rising at cycle t → `trig_rst` high t+1 … t+RESET_CYCLES → `capture_en` high at t+1+RESET_CYCLES+SETTLE_CYCLES.
- **Flush relative to capture.** `capture_flush` is asserted in the same cycle that `capture_en` falls.
- **`download_done`.** Ignored outside DONE.

## Structure
- **Package `logic_trig_pkg`:**
  - `trig_state_t` enum: IDLE=0 … CLEAR=6;
  - default constants for RESET_CYCLES and SETTLE_CYCLES.
- **Sub-module `logic_trigger_match`:**
  - parametrised on NUM_CHANNELS;
  - owns `s_q` and `s_qq`;
  - outputs a combinational `match` from the registered samples.
- The sequencer holds the FSM, the counters and the config latch.

## Test plan
- **Basic single shot.** pre=4, post=8, mask=0x1, value=0x1, `sample` bit0 rises at cycle t while ARMED → `triggered` at t+2, then after 8 POST_TRIG cycles `capture_flush` pulses once and `capture_en` falls in that cycle; after `download_done`, state=CLEAR and `acq_count`=1.
- **Auto timeout.** auto_trig=1, auto_timeout=10, mask never matches → `triggered` exactly 10 cycles after entering ARMED, `trig_was_auto`=1.
- **Edge trigger.** edge_mask=0x4, mask=0, bit2 static → no trigger. Toggle bit2 → trigger 2 cycles later.
- **Repeat mode.** repeat_mode=1, arm held high, three `download_done` pulses → three full acquisitions, `acq_count`=3, `trig_rst` high RESET_CYCLES cycles each time.
- **Abort and zero sizes.**
  - `arm_req` dropped mid-POST_TRIG → next cycle IDLE, `capture_en`=0, no flush.
  - pre=0 → PRE_TRIG never entered.
  - post=0 → flush on first POST_TRIG cycle.
- **Reset mid-run.** Assert `rst` during ARMED → next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/logic_trig_pkg.sv
// rtl/logic_trig_pkg.sv - shared types and defaults for the logic-analyzer trigger sequencer
package logic_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_PRE_TRIG  = 3'd2,
        ST_ARMED     = 3'd3,
        ST_POST_TRIG = 3'd4,
        ST_DONE      = 3'd5,
        ST_CLEAR     = 3'd6
    } trig_state_t;

    localparam int DEFAULT_RESET_CYCLES  = 32;
    localparam int DEFAULT_SETTLE_CYCLES = 32;

endpackage

// File: rtl/logic_trigger_match.sv
// rtl/logic_trigger_match.sv - registered sample history and pattern/edge match evaluation
module logic_trigger_match #(
    parameter int NUM_CHANNELS = 16
) (
    input  logic                    clk_ram_2x,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] sample,
    input  logic [NUM_CHANNELS-1:0] trig_mask,
    input  logic [NUM_CHANNELS-1:0] trig_value,
    input  logic [NUM_CHANNELS-1:0] trig_edge_mask,
    output logic                    match
);

    logic [NUM_CHANNELS-1:0] s_q;
    logic [NUM_CHANNELS-1:0] s_qq;

    // Two-deep sample history: current registered sample and the one before it
    always_ff @(posedge clk_ram_2x) begin
        if (rst) begin
            s_q  <= '0;
            s_qq <= '0;
        end else begin
            s_q  <= sample;
            s_qq <= s_q;
        end
    end

    // Level match on masked channels, qualified by a change on any edge channel
    assign match = (((s_q ^ trig_value) & trig_mask) == '0) &&
                   ((trig_edge_mask == '0) || (((s_q ^ s_qq) & trig_edge_mask) != '0));

endmodule

// File: rtl/logic_trigger_sequencer.sv
// rtl/logic_trigger_sequencer.sv - acquisition FSM: reset, pre/post-trigger windows, trigger, download
module logic_trigger_sequencer
    import logic_trig_pkg::*;
#(
    parameter int NUM_CHANNELS  = 16,
    parameter int COUNT_WIDTH   = 32,
    parameter int RESET_CYCLES  = DEFAULT_RESET_CYCLES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                    clk_ram_2x,
    input  logic                    rst,
    input  logic                    arm_req,
    input  logic                    repeat_mode,
    input  logic                    auto_trig,
    input  logic                    force_trig,
    input  logic [COUNT_WIDTH-1:0]  pre_trig_size,
    input  logic [COUNT_WIDTH-1:0]  post_trig_size,
    input  logic [COUNT_WIDTH-1:0]  auto_timeout,
    input  logic [NUM_CHANNELS-1:0] trig_mask,
    input  logic [NUM_CHANNELS-1:0] trig_value,
    input  logic [NUM_CHANNELS-1:0] trig_edge_mask,
    input  logic [NUM_CHANNELS-1:0] sample,
    input  logic                    download_done,
    output logic                    trig_rst,
    output logic                    capture_en,
    output logic                    capture_flush,
    output logic                    triggered,
    output logic                    trig_was_auto,
    output logic [2:0]              trig_state,
    output logic [15:0]             acq_count
);

    localparam logic [COUNT_WIDTH-1:0] RST_LAST    = COUNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST = COUNT_WIDTH'(RESET_CYCLES + SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

    trig_state_t             state;
    logic [COUNT_WIDTH-1:0]  cnt;

    logic [COUNT_WIDTH-1:0]  cfg_pre;
    logic [COUNT_WIDTH-1:0]  cfg_post;
    logic [COUNT_WIDTH-1:0]  cfg_tmo;
    logic [NUM_CHANNELS-1:0] cfg_mask;
    logic [NUM_CHANNELS-1:0] cfg_value;
    logic [NUM_CHANNELS-1:0] cfg_edge;
    logic                    cfg_auto;
    logic                    cfg_repeat;

    logic match;
    logic busy;
    logic arm_start;
    logic rearm;
    logic pre_last;
    logic post_last;
    logic timeout_hit;
    logic fire;

    logic_trigger_match #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_match (
        .clk_ram_2x     (clk_ram_2x),
        .rst            (rst),
        .sample         (sample),
        .trig_mask      (cfg_mask),
        .trig_value     (cfg_value),
        .trig_edge_mask (cfg_edge),
        .match          (match)
    );

    assign busy        = (state == ST_RESET) || (state == ST_PRE_TRIG) ||
                         (state == ST_ARMED) || (state == ST_POST_TRIG);
    assign arm_start   = (state == ST_IDLE) && arm_req;
    assign rearm       = (state == ST_DONE) && download_done && cfg_repeat && arm_req;
    assign pre_last    = (cnt == cfg_pre - ONE);
    assign post_last   = (cfg_post == '0) || (cnt == cfg_post - ONE);
    assign timeout_hit = cfg_auto && ((cfg_tmo == '0) || (cnt == cfg_tmo - ONE));
    assign fire        = match || force_trig || timeout_hit;
    assign trig_state  = state;

    // Snapshot of the run configuration, taken whenever a new acquisition starts
    always_ff @(posedge clk_ram_2x) begin
        if (rst) begin
            cfg_pre    <= '0;
            cfg_post   <= '0;
            cfg_tmo    <= '0;
            cfg_mask   <= '0;
            cfg_value  <= '0;
            cfg_edge   <= '0;
            cfg_auto   <= 1'b0;
            cfg_repeat <= 1'b0;
        end else if (arm_start || rearm) begin
            cfg_pre    <= pre_trig_size;
            cfg_post   <= post_trig_size;
            cfg_tmo    <= auto_timeout;
            cfg_mask   <= trig_mask;
            cfg_value  <= trig_value;
            cfg_edge   <= trig_edge_mask;
            cfg_auto   <= auto_trig;
            cfg_repeat <= repeat_mode;
        end
    end

    // Acquisition FSM with registered control outputs; abort overrides every other event
    always_ff @(posedge clk_ram_2x) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            trig_rst      <= 1'b0;
            capture_en    <= 1'b0;
            capture_flush <= 1'b0;
            triggered     <= 1'b0;
            trig_was_auto <= 1'b0;
            acq_count     <= '0;
        end else begin
            capture_flush <= 1'b0;
            triggered     <= 1'b0;
            if (busy && !arm_req) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                trig_rst   <= 1'b0;
                capture_en <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm_req) begin
                            state    <= ST_RESET;
                            trig_rst <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                    ST_RESET: begin
                        cnt <= cnt + ONE;
                        if (cnt == RST_LAST) begin
                            trig_rst <= 1'b0;
                        end
                        if (cnt == SETTLE_LAST) begin
                            capture_en <= 1'b1;
                            cnt        <= '0;
                            state      <= (cfg_pre == '0) ? ST_ARMED : ST_PRE_TRIG;
                        end
                    end
                    ST_PRE_TRIG: begin
                        cnt <= cnt + ONE;
                        if (pre_last) begin
                            cnt   <= '0;
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        cnt <= cnt + ONE;
                        if (fire) begin
                            triggered     <= 1'b1;
                            trig_was_auto <= !match;
                            cnt           <= '0;
                            state         <= ST_POST_TRIG;
                        end
                    end
                    ST_POST_TRIG: begin
                        cnt <= cnt + ONE;
                        if (post_last) begin
                            capture_en    <= 1'b0;
                            capture_flush <= 1'b1;
                            cnt           <= '0;
                            state         <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (download_done) begin
                            acq_count <= acq_count + 16'd1;
                            if (cfg_repeat && arm_req) begin
                                state    <= ST_RESET;
                                trig_rst <= 1'b1;
                                cnt      <= '0;
                            end else begin
                                state <= ST_CLEAR;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        if (!arm_req) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_logic_trigger_sequencer.sv
// tb/tb_logic_trigger_sequencer.sv - self-checking bench for logic_trigger_sequencer
module tb_logic_trigger_sequencer;

    localparam int NC   = 8;
    localparam int CW   = 16;
    localparam int RC   = 3;
    localparam int SC   = 2;
    localparam int KMAX = 128;
    localparam int NEVER = 100000;

    logic          clk_ram_2x = 1'b0;
    logic          rst = 1'b1;
    logic          arm_req = 1'b0;
    logic          repeat_mode = 1'b0;
    logic          auto_trig = 1'b0;
    logic          force_trig = 1'b0;
    logic [CW-1:0] pre_trig_size = '0;
    logic [CW-1:0] post_trig_size = '0;
    logic [CW-1:0] auto_timeout = '0;
    logic [NC-1:0] trig_mask = '0;
    logic [NC-1:0] trig_value = '0;
    logic [NC-1:0] trig_edge_mask = '0;
    logic [NC-1:0] sample = '0;
    logic          download_done = 1'b0;
    logic          trig_rst;
    logic          capture_en;
    logic          capture_flush;
    logic          triggered;
    logic          trig_was_auto;
    logic [2:0]    trig_state;
    logic [15:0]   acq_count;

    int   total = 0;
    int   bad = 0;
    int   n_acq = 0;
    logic prev_auto = 1'b0;
    logic [NC-1:0] samp [KMAX];

    always #5 clk_ram_2x = ~clk_ram_2x;

    logic_trigger_sequencer #(
        .NUM_CHANNELS (NC),
        .COUNT_WIDTH  (CW),
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk_ram_2x    (clk_ram_2x),
        .rst           (rst),
        .arm_req       (arm_req),
        .repeat_mode   (repeat_mode),
        .auto_trig     (auto_trig),
        .force_trig    (force_trig),
        .pre_trig_size (pre_trig_size),
        .post_trig_size(post_trig_size),
        .auto_timeout  (auto_timeout),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .trig_edge_mask(trig_edge_mask),
        .sample        (sample),
        .download_done (download_done),
        .trig_rst      (trig_rst),
        .capture_en    (capture_en),
        .capture_flush (capture_flush),
        .triggered     (triggered),
        .trig_was_auto (trig_was_auto),
        .trig_state    (trig_state),
        .acq_count     (acq_count)
    );

    task automatic step();
        @(posedge clk_ram_2x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic spec_match(input int j, input logic [NC-1:0] mask,
                                        input logic [NC-1:0] value, input logic [NC-1:0] emask);
        logic [NC-1:0] cur;
        logic [NC-1:0] prv;
        cur = samp[j-1];
        prv = samp[j-2];
        return (((cur ^ value) & mask) == '0) && ((emask == '0) || (((cur ^ prv) & emask) != '0));
    endfunction

    task automatic scramble_cfg();
        pre_trig_size  = CW'($urandom);
        post_trig_size = CW'($urandom);
        auto_timeout   = CW'($urandom);
        trig_mask      = NC'($urandom);
        trig_value     = NC'($urandom);
        trig_edge_mask = NC'($urandom);
        auto_trig      = 1'($urandom);
        repeat_mode    = 1'($urandom);
    endtask

    task automatic fill_const(input logic [NC-1:0] v);
        for (int i = 0; i < KMAX; i++) samp[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < KMAX; i++) samp[i] = NC'($urandom);
    endtask

    // One acquisition, checked cycle by cycle against a timeline derived from the rules.
    // kind: 0 none, 1 arm_req drop, 2 rst pulse; abort_after >= 0 places the abort relative to the trigger.
    task automatic run_acq(input int pre, input int post, input int tmo, input logic auto_t, input logic rep,
                           input logic [NC-1:0] mask, input logic [NC-1:0] value, input logic [NC-1:0] emask,
                           input int fk, input int kind, input int abort_at, input int abort_after,
                           input logic via_done);
        int   k_ce, k_a, k_t, k_f, abort_k, kend, exp_st;
        logic wa, past, m;
        k_ce = 1 + RC + SC;
        k_a  = k_ce + pre;
        k_t  = NEVER;
        wa   = 1'b0;
        for (int j = k_a; j < KMAX - 1; j++) begin
            m = spec_match(j, mask, value, emask);
            if (m || j == fk || (auto_t && (tmo == 0 || j - k_a == tmo - 1))) begin
                k_t = j + 1;
                wa  = !m;
                break;
            end
        end
        abort_k = (abort_after >= 0) ? k_t + abort_after : abort_at;
        if (kind != 0 && k_t - 1 >= abort_k) k_t = NEVER;
        k_f  = k_t + ((post == 0) ? 1 : post);
        kend = (kind != 0) ? abort_k + 1 : k_f + 1;

        pre_trig_size  = CW'(pre);
        post_trig_size = CW'(post);
        auto_timeout   = CW'(tmo);
        auto_trig      = auto_t;
        repeat_mode    = rep;
        trig_mask      = mask;
        trig_value     = value;
        trig_edge_mask = emask;
        force_trig     = (fk == 0);
        sample         = samp[0];
        if (via_done) begin
            download_done = 1'b1;
            n_acq++;
        end else begin
            arm_req = 1'b1;
        end

        for (int k = 1; k <= kend; k++) begin
            step();
            past = (kind != 0) && (k > abort_k);
            if (past)          exp_st = 0;
            else if (k < k_ce) exp_st = 1;
            else if (k < k_a)  exp_st = 2;
            else if (k < k_t)  exp_st = 3;
            else if (k < k_f)  exp_st = 4;
            else               exp_st = 5;
            chk("state", 32'(trig_state), 32'(exp_st));
            chk("trig_rst", 32'(trig_rst), 32'(!past && k <= RC));
            chk("capture_en", 32'(capture_en), 32'(!past && k >= k_ce && k < k_f));
            chk("capture_flush", 32'(capture_flush), 32'(!past && k == k_f));
            chk("triggered", 32'(triggered), 32'(!past && k == k_t));
            chk("trig_was_auto", 32'(trig_was_auto),
                32'((past && kind == 2) ? 1'b0 : ((k >= k_t) ? wa : prev_auto)));
            chk("acq_count", 32'(acq_count), (past && kind == 2) ? 32'd0 : 32'(n_acq));

            download_done = (k < k_f) ? 1'($urandom) : 1'b0;
            force_trig    = (k == fk);
            sample        = samp[k];
            scramble_cfg();
            if (kind == 1 && k == abort_k) arm_req = 1'b0;
            if (kind == 2 && k == abort_k) rst = 1'b1;
            if (kind == 2 && k == abort_k + 1) begin
                rst     = 1'b0;
                arm_req = 1'b0;
            end
        end
        download_done = 1'b0;
        force_trig    = 1'b0;
        if (kind == 2) begin
            n_acq     = 0;
            prev_auto = 1'b0;
        end else if (k_t != NEVER) begin
            prev_auto = wa;
        end
    endtask

    // Consume the waveform in DONE; keep = hold arm_req high through CLEAR first.
    task automatic done_exit(input logic keep);
        arm_req       = keep;
        download_done = 1'b1;
        step();
        download_done = 1'b0;
        n_acq++;
        chk("dl_acq_count", 32'(acq_count), 32'(n_acq & 16'hffff));
        chk("dl_state_clear", 32'(trig_state), 32'd6);
        chk("dl_capture_en", 32'(capture_en), 32'd0);
        if (keep) begin
            step();
            chk("clear_hold", 32'(trig_state), 32'd6);
            arm_req = 1'b0;
        end
        step();
        chk("back_idle", 32'(trig_state), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_a;
        logic chain;
        logic rep;
        logic [NC-1:0] rm;
        logic [NC-1:0] re;

        fill_const('0);
        rst = 1'b1;
        repeat (3) step();
        chk("rst_state", 32'(trig_state), 32'd0);
        chk("rst_trig_rst", 32'(trig_rst), 32'd0);
        chk("rst_capture_en", 32'(capture_en), 32'd0);
        chk("rst_flush", 32'(capture_flush), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_was_auto", 32'(trig_was_auto), 32'd0);
        chk("rst_acq_count", 32'(acq_count), 32'd0);
        rst = 1'b0;
        step();

        download_done = 1'b1;
        step();
        download_done = 1'b0;
        chk("idle_dl_ignored", 32'(acq_count), 32'd0);
        chk("idle_dl_state", 32'(trig_state), 32'd0);

        // basic single shot: bit0 rises 3 cycles into ARMED
        k_a = 1 + RC + SC + 4;
        fill_const('0);
        for (int i = k_a + 3; i < KMAX; i++) samp[i] = 8'h01;
        run_acq(4, 8, 0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, -1, 0, 0, -1, 1'b0);
        done_exit(1'b1);

        // auto timeout with a pattern that never matches
        fill_const('0);
        run_acq(2, 3, 10, 1'b1, 1'b0, 8'hff, 8'haa, 8'h00, -1, 0, 0, -1, 1'b0);
        done_exit(1'b0);

        // edge trigger: bit2 static, then toggles
        k_a = 1 + RC + SC + 1;
        for (int i = 0; i < KMAX; i++) samp[i] = NC'($urandom) | 8'h04;
        for (int i = k_a + 8; i < KMAX; i++) samp[i] = samp[i] & 8'hfb;
        run_acq(1, 2, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h04, -1, 0, 0, -1, 1'b0);
        done_exit(1'b0);

        // force with no match, then force coinciding with a match
        k_a = 1 + RC + SC + 2;
        fill_const('0);
        run_acq(2, 2, 0, 1'b0, 1'b0, 8'hff, 8'h55, 8'h00, k_a + 4, 0, 0, -1, 1'b0);
        done_exit(1'b0);
        run_acq(2, 2, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, k_a, 0, 0, -1, 1'b0);
        done_exit(1'b0);

        // repeat mode: three back-to-back acquisitions
        fill_rand();
        run_acq(1, 3, 4, 1'b1, 1'b1, 8'h03, 8'h01, 8'h00, -1, 0, 0, -1, 1'b0);
        run_acq(0, 2, 3, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, -1, 0, 0, -1, 1'b1);
        run_acq(2, 1, 6, 1'b1, 1'b1, 8'h10, 8'h10, 8'h20, -1, 0, 0, -1, 1'b1);
        done_exit(1'b0);

        // zero pre and zero post sizes
        fill_rand();
        run_acq(0, 4, 5, 1'b1, 1'b0, 8'h03, 8'h03, 8'h00, -1, 0, 0, -1, 1'b0);
        done_exit(1'b0);
        run_acq(3, 0, 5, 1'b1, 1'b0, 8'h0c, 8'h04, 8'h00, -1, 0, 0, -1, 1'b0);
        done_exit(1'b0);

        // abort mid POST_TRIG, abort in RESET
        run_acq(1, 8, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1, 1, 0, 3, 1'b0);
        chk("abort_no_flush", 32'(capture_flush), 32'd0);
        fill_const('0);
        run_acq(2, 2, 0, 1'b0, 1'b0, 8'hff, 8'h55, 8'h00, -1, 1, 2, -1, 1'b0);

        // synchronous reset while ARMED
        run_acq(0, 2, 0, 1'b0, 1'b0, 8'hff, 8'h55, 8'h00, -1, 2, 1 + RC + SC + 2, -1, 1'b0);
        step();
        chk("post_rst_idle", 32'(trig_state), 32'd0);

        // randomized acquisitions
        chain = 1'b0;
        for (int it = 0; it < 14; it++) begin
            fill_rand();
            rep = 1'($urandom);
            rm  = (NC'(1) << $urandom_range(0, NC - 1)) | (NC'(1) << $urandom_range(0, NC - 1));
            re  = ($urandom_range(0, 1) == 1) ? (NC'(1) << $urandom_range(0, NC - 1)) : NC'(0);
            k_a = 1 + RC + SC;
            if (!chain && $urandom_range(0, 3) == 0) begin
                run_acq($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 15), 1'b1, rep,
                        rm, NC'($urandom), re, -1, 1, $urandom_range(1, 12), -1, 1'b0);
                chain = 1'b0;
            end else begin
                run_acq($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 15), 1'b1, rep,
                        rm, NC'($urandom), re,
                        ($urandom_range(0, 1) == 1) ? k_a + $urandom_range(0, 10) : -1,
                        0, 0, -1, chain);
                chain = rep && ($urandom_range(0, 1) == 1);
                if (!chain) done_exit(rep ? 1'b0 : 1'($urandom));
            end
        end
        if (chain) done_exit(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
